// File: rtl/xvk_cam_pkg.sv
// Shared types and helpers for the multi-search CAM.
// Build option XVK_CAM_TERNARY_EN (used by xvk_cam_msrch) adds per-entry don't-care masks.
package xvk_cam_pkg;

    localparam int unsigned MaxAddrW = 16;
    localparam int unsigned MaxDepth = 256;

    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic                hit;
        logic                multi;
        logic [MaxAddrW-1:0] addr;
    } rslt_t;

    function automatic logic [8:0] popcount(input logic [MaxDepth-1:0] v);
        logic [8:0] n;
        n = '0;
        for (int i = 0; i < int'(MaxDepth); i++) begin
            n = n + 9'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/xvk_cam_prio_enc.sv
// Priority encoder: reports any/multiple set bits and the winning index (high- or low-first).
module xvk_cam_prio_enc
    import xvk_cam_pkg::*;
#(
    parameter  int unsigned DEPTH      = 16,
    parameter  bit          HIGH_FIRST = 1'b0,
    localparam int unsigned AW         = addr_w(DEPTH)
) (
    input  logic [DEPTH-1:0] vec_i,
    output logic             any_o,
    output logic             multi_o,
    output logic [AW-1:0]    idx_o
);

    always_comb begin
        any_o   = |vec_i;
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi_o = |(vec_i & (vec_i - DEPTH'(1)));
        idx_o   = '0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (vec_i[i]) idx_o = AW'(i);
            end
        end else begin
            for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
                if (vec_i[i]) idx_o = AW'(i);
            end
        end
    end

endmodule

// File: rtl/xvk_cam_msrch.sv
// Multi-channel CAM with valid bits, write bypass, free-slot search and occupancy count.
// Define XVK_CAM_TERNARY_EN to add the wr_mask port and per-entry don't-care masks.
module xvk_cam_msrch
    import xvk_cam_pkg::*;
#(
    parameter  int unsigned CAM_WIDTH = 13,
    parameter  int unsigned CAM_DEPTH = 16,
    parameter  int unsigned NUM_SRCH  = 2,
    parameter  bit          PRIO_HIGH = 1'b1,
    localparam int unsigned AW        = addr_w(CAM_DEPTH),
    localparam int unsigned OccW      = AW + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [CAM_WIDTH-1:0]      wr_din,
`ifdef XVK_CAM_TERNARY_EN
    input  logic [CAM_WIDTH-1:0]      wr_mask,
`endif
    input  logic                      inv_en,
    input  logic [AW-1:0]             inv_addr,
    input  logic                      flush,
    input  logic [NUM_SRCH-1:0]       srch_en,
    input  logic [NUM_SRCH*CAM_WIDTH-1:0] srch_key,
    output logic [NUM_SRCH-1:0]       rslt_vld,
    output logic [NUM_SRCH-1:0]       rslt_hit,
    output logic [NUM_SRCH-1:0]       rslt_multi,
    output logic [NUM_SRCH*AW-1:0]    rslt_addr,
    output logic                      free_vld,
    output logic [AW-1:0]             free_addr,
    output logic [OccW-1:0]           occupancy
);

    logic [CAM_DEPTH-1:0] valid_q, valid_d;
    logic [CAM_DEPTH-1:0] wr_sel, inv_sel;
    logic [CAM_WIDTH-1:0] data_q [CAM_DEPTH];
    logic [CAM_WIDTH-1:0] data_d [CAM_DEPTH];
`ifdef XVK_CAM_TERNARY_EN
    logic [CAM_WIDTH-1:0] mask_q [CAM_DEPTH];
    logic [CAM_WIDTH-1:0] mask_d [CAM_DEPTH];
`endif

    // data_d doubles as the bypassed search view; write beats invalidate beats flush.
    always_comb begin
        for (int k = 0; k < int'(CAM_DEPTH); k++) begin
            wr_sel[k]  = wr_en && (wr_addr == AW'(k));
            inv_sel[k] = inv_en && (inv_addr == AW'(k));
            data_d[k]  = wr_sel[k] ? wr_din : data_q[k];
`ifdef XVK_CAM_TERNARY_EN
            mask_d[k]  = wr_sel[k] ? wr_mask : mask_q[k];
`endif
            valid_d[k] = wr_sel[k] | (valid_q[k] & ~inv_sel[k] & ~flush);
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
`ifdef XVK_CAM_TERNARY_EN
        mask_q <= mask_d;
`endif
    end

    for (genvar c = 0; c < int'(NUM_SRCH); c++) begin : g_srch
        logic [CAM_WIDTH-1:0] key;
        logic [CAM_DEPTH-1:0] match;
        logic                 any, multi;
        logic [AW-1:0]        idx;
        rslt_t                rslt_q, rslt_d;
        logic                 vld_q, vld_d;
        logic                 unused_addr;

        assign key = srch_key[c*CAM_WIDTH +: CAM_WIDTH];

        always_comb begin
            for (int k = 0; k < int'(CAM_DEPTH); k++) begin
`ifdef XVK_CAM_TERNARY_EN
                match[k] = valid_d[k] && (((key ^ data_d[k]) & ~mask_d[k]) == '0);
`else
                match[k] = valid_d[k] && (key == data_d[k]);
`endif
            end
        end

        xvk_cam_prio_enc #(
            .DEPTH      (CAM_DEPTH),
            .HIGH_FIRST (PRIO_HIGH)
        ) u_enc (
            .vec_i   (match),
            .any_o   (any),
            .multi_o (multi),
            .idx_o   (idx)
        );

        always_comb begin
            vld_d  = srch_en[c];
            rslt_d = rslt_q;
            if (srch_en[c]) begin
                rslt_d.hit   = any;
                rslt_d.multi = multi;
                rslt_d.addr  = MaxAddrW'(idx);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q  <= 1'b0;
                rslt_q <= '0;
            end else begin
                vld_q  <= vld_d;
                rslt_q <= rslt_d;
            end
        end

        assign rslt_vld[c]          = vld_q;
        assign rslt_hit[c]          = rslt_q.hit;
        assign rslt_multi[c]        = rslt_q.multi;
        assign rslt_addr[c*AW +: AW] = rslt_q.addr[AW-1:0];
        assign unused_addr          = ^rslt_q.addr;
    end

    logic            free_any, free_multi;
    logic [AW-1:0]   free_idx;
    logic            free_vld_q, free_vld_d;
    logic [AW-1:0]   free_addr_q, free_addr_d;
    logic [OccW-1:0] occupancy_q, occupancy_d;

    xvk_cam_prio_enc #(
        .DEPTH      (CAM_DEPTH),
        .HIGH_FIRST (1'b0)
    ) u_free_enc (
        .vec_i   (~valid_d),
        .any_o   (free_any),
        .multi_o (free_multi),
        .idx_o   (free_idx)
    );

    always_comb begin
        free_vld_d  = free_any;
        free_addr_d = free_idx;
        occupancy_d = OccW'(popcount(MaxDepth'(valid_d)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            free_vld_q  <= 1'b1;
            free_addr_q <= '0;
            occupancy_q <= '0;
        end else begin
            valid_q     <= valid_d;
            free_vld_q  <= free_vld_d;
            free_addr_q <= free_addr_d;
            occupancy_q <= occupancy_d;
        end
    end

    logic unused_free;
    assign unused_free = free_multi;

    assign free_vld  = free_vld_q;
    assign free_addr = free_addr_q;
    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_xvk_cam_msrch.sv
// Bench for xvk_cam_msrch: two instances (high/low priority) against a behavioural entry-list model.
module tb_xvk_cam_msrch;

    localparam int W  = 13;
    localparam int D  = 16;
    localparam int NS = 2;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            wr_en, inv_en, flush;
    logic [AW-1:0]   wr_addr, inv_addr;
    logic [W-1:0]    wr_din, wr_mask;
    logic [NS-1:0]   srch_en;
    logic [NS*W-1:0] srch_key;

    logic [NS-1:0]    vld_h, hit_h, multi_h, vld_l, hit_l, multi_l;
    logic [NS*AW-1:0] addr_h, addr_l;
    logic             fv_h, fv_l;
    logic [AW-1:0]    fa_h, fa_l;
    logic [AW:0]      occ_h, occ_l;

    xvk_cam_msrch #(.CAM_WIDTH(W), .CAM_DEPTH(D), .NUM_SRCH(NS), .PRIO_HIGH(1'b1)) u_hi (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din),
`ifdef XVK_CAM_TERNARY_EN
        .wr_mask(wr_mask),
`endif
        .inv_en(inv_en), .inv_addr(inv_addr), .flush(flush), .srch_en(srch_en),
        .srch_key(srch_key), .rslt_vld(vld_h), .rslt_hit(hit_h), .rslt_multi(multi_h),
        .rslt_addr(addr_h), .free_vld(fv_h), .free_addr(fa_h), .occupancy(occ_h)
    );

    xvk_cam_msrch #(.CAM_WIDTH(W), .CAM_DEPTH(D), .NUM_SRCH(NS), .PRIO_HIGH(1'b0)) u_lo (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din),
`ifdef XVK_CAM_TERNARY_EN
        .wr_mask(wr_mask),
`endif
        .inv_en(inv_en), .inv_addr(inv_addr), .flush(flush), .srch_en(srch_en),
        .srch_key(srch_key), .rslt_vld(vld_l), .rslt_hit(hit_l), .rslt_multi(multi_l),
        .rslt_addr(addr_l), .free_vld(fv_l), .free_addr(fa_l), .occupancy(occ_l)
    );

    // Reference model: entry list plus expected registered outputs ([0]=high-first, [1]=low-first)
    bit           mv [D];
    logic [W-1:0] md [D];
    logic [W-1:0] mm [D];
    bit           e_vld [NS];
    bit           e_hit [2][NS];
    bit           e_multi [2][NS];
    int           e_addr [2][NS];
    int           e_occ, e_fa;
    bit           e_fv;

    int n_chk = 0;
    int n_pass = 0;
    logic [W-1:0] pool [4] = '{13'h0AB, 13'h055, 13'h111, 13'h1FFF};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        for (int c = 0; c < NS; c++) begin
            chk($sformatf("vld_hi[%0d]", c), 32'(vld_h[c]), 32'(e_vld[c]));
            chk($sformatf("vld_lo[%0d]", c), 32'(vld_l[c]), 32'(e_vld[c]));
            chk($sformatf("hit_hi[%0d]", c), 32'(hit_h[c]), 32'(e_hit[0][c]));
            chk($sformatf("hit_lo[%0d]", c), 32'(hit_l[c]), 32'(e_hit[1][c]));
            chk($sformatf("multi_hi[%0d]", c), 32'(multi_h[c]), 32'(e_multi[0][c]));
            chk($sformatf("multi_lo[%0d]", c), 32'(multi_l[c]), 32'(e_multi[1][c]));
            chk($sformatf("addr_hi[%0d]", c), 32'(addr_h[c*AW +: AW]), 32'(e_addr[0][c]));
            chk($sformatf("addr_lo[%0d]", c), 32'(addr_l[c*AW +: AW]), 32'(e_addr[1][c]));
        end
        chk("occ_hi", 32'(occ_h), 32'(e_occ));
        chk("occ_lo", 32'(occ_l), 32'(e_occ));
        chk("free_vld_hi", 32'(fv_h), 32'(e_fv));
        chk("free_vld_lo", 32'(fv_l), 32'(e_fv));
        chk("free_addr_hi", 32'(fa_h), 32'(e_fa));
        chk("free_addr_lo", 32'(fa_l), 32'(e_fa));
    endtask

    task automatic model_reset();
        for (int k = 0; k < D; k++) mv[k] = 1'b0;
        for (int c = 0; c < NS; c++) begin
            e_vld[c] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                e_hit[p][c] = 1'b0; e_multi[p][c] = 1'b0; e_addr[p][c] = 0;
            end
        end
        e_occ = 0; e_fv = 1'b1; e_fa = 0;
    endtask

    task automatic model_update();
        int q[$];
        logic [W-1:0] key;
        logic [W-1:0] mk;
`ifdef XVK_CAM_TERNARY_EN
        mk = wr_mask;
`else
        mk = '0;
`endif
        // Apply lowest priority first so later events override earlier ones.
        if (flush) for (int k = 0; k < D; k++) mv[k] = 1'b0;
        if (inv_en) mv[inv_addr] = 1'b0;
        if (wr_en) begin
            mv[wr_addr] = 1'b1; md[wr_addr] = wr_din; mm[wr_addr] = mk;
        end
        for (int c = 0; c < NS; c++) begin
            e_vld[c] = srch_en[c];
            if (srch_en[c]) begin
                key = srch_key[c*W +: W];
                q.delete();
                for (int k = 0; k < D; k++)
                    if (mv[k] && (((key ^ md[k]) & ~mm[k]) == '0)) q.push_back(k);
                for (int p = 0; p < 2; p++) begin
                    e_hit[p][c]   = (q.size() > 0);
                    e_multi[p][c] = (q.size() > 1);
                end
                e_addr[0][c] = (q.size() > 0) ? q[q.size()-1] : 0;
                e_addr[1][c] = (q.size() > 0) ? q[0] : 0;
            end
        end
        e_occ = 0; e_fa = -1;
        for (int k = 0; k < D; k++) begin
            if (mv[k]) e_occ++;
            else if (e_fa < 0) e_fa = k;
        end
        e_fv = (e_occ < D);
        if (e_fa < 0) e_fa = 0;
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_din = '0; wr_mask = '0;
        inv_en = 1'b0; inv_addr = '0; flush = 1'b0;
        srch_en = '0; srch_key = '0;
    endtask

    task automatic write(input int a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_din = d;
    endtask

    task automatic search(input int c, input logic [W-1:0] key);
        srch_en[c] = 1'b1; srch_key[c*W +: W] = key;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_all();
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        write(3, 13'h0AB); step();
        search(0, 13'h0AB); step();

        write(2, 13'h055); step();
        write(9, 13'h055); step();
        search(0, 13'h055); search(1, 13'h055); step();

        // write bypass, then invalidate hiding an entry in the same cycle
        write(5, 13'h111); search(1, 13'h111); step();
        inv_en = 1'b1; inv_addr = 4'd3; search(0, 13'h0AB); step();
        inv_en = 1'b1; inv_addr = 4'd3; step();

        for (int i = 0; i < D; i++) begin
            write(i, 13'(13'h200 + i)); step();
        end
        flush = 1'b1; write(7, 13'h333); step();
        search(0, 13'h333); search(1, 13'h207); step();

        // reset mid-search drops the pending result at once
        search(0, 13'h333); search(1, 13'h333);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        search(0, 13'h333); search(1, 13'h0AB); step();

`ifdef XVK_CAM_TERNARY_EN
        write(4, 13'h0F0); wr_mask = 13'h00F; step();
        search(0, 13'h0F7); search(1, 13'h1F0); step();
`endif

        for (int n = 0; n < 400; n++) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = AW'($urandom_range(0, D - 1));
            wr_din   = pool[$urandom_range(0, 3)];
`ifdef XVK_CAM_TERNARY_EN
            wr_mask  = ($urandom_range(0, 3) == 0) ? W'($urandom) & 13'h00F : '0;
`endif
            inv_en   = ($urandom_range(0, 2) == 0);
            inv_addr = AW'($urandom_range(0, D - 1));
            flush    = ($urandom_range(0, 39) == 0);
            srch_en  = NS'($urandom_range(0, 3));
            for (int c = 0; c < NS; c++) srch_key[c*W +: W] = pool[$urandom_range(0, 3)];
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
